// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: CPU and DMA requester ports, the shared memory port,
// and the error/ownership status. slave = arbiter side, master = requesters + memory.
interface mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          c_req, c_we, c_ack;
    logic [AW-1:0] c_adr;
    logic [DW-1:0] c_wdata, c_rdata;

    logic          d_req, d_we, d_last, d_ack;
    logic [AW-1:0] d_adr;
    logic [DW-1:0] d_wdata, d_rdata;

    logic          m_req, m_we, m_ack;
    logic [AW-1:0] m_adr;
    logic [DW-1:0] m_wdata, m_rdata;

    logic          err, err_clr, owner;

    modport slave (
        input  c_req, c_we, c_adr, c_wdata,
        output c_rdata, c_ack,
        input  d_req, d_we, d_last, d_adr, d_wdata,
        output d_rdata, d_ack,
        output m_req, m_we, m_adr, m_wdata,
        input  m_rdata, m_ack,
        output err, owner,
        input  err_clr
    );

    modport master (
        output c_req, c_we, c_adr, c_wdata,
        input  c_rdata, c_ack,
        output d_req, d_we, d_last, d_adr, d_wdata,
        input  d_rdata, d_ack,
        input  m_req, m_we, m_adr, m_wdata,
        output m_rdata, m_ack,
        input  err, owner,
        output err_clr
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between CPU and DMA, with bounded
// DMA bursts and an access timeout that raises a sticky error flag.
module mem_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAXBURST = 4,
    parameter int TIMEOUT  = 255
) (
    input logic          clk,
    input logic          reset,
    mem_arbiter_if.slave bus
);
    localparam int BW = $clog2(MAXBURST + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, ACC_C, ACC_D, RESP_C, RESP_D} state_t;

    state_t        state_q, state_d;
    logic          m_req_q, m_req_d, m_we_q, m_we_d;
    logic [AW-1:0] m_adr_q, m_adr_d;
    logic [DW-1:0] m_wdata_q, m_wdata_d;
    logic          c_ack_q, c_ack_d, d_ack_q, d_ack_d;
    logic [DW-1:0] c_rdata_q, c_rdata_d, d_rdata_q, d_rdata_d;
    logic          err_q, err_d, owner_q, owner_d;
    logic          last_q, last_d;        // d_last of the most recent DMA grant
    logic          pref_dma_q, pref_dma_d; // tie goes to DMA when CPU was served last
    logic [BW-1:0] burst_q, burst_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          lock, grant_dma, done, tmo_hit;

    always_comb begin
        state_d    = state_q;
        m_req_d    = 1'b0;
        m_we_d     = m_we_q;
        m_adr_d    = m_adr_q;
        m_wdata_d  = m_wdata_q;
        c_ack_d    = 1'b0;
        d_ack_d    = 1'b0;
        c_rdata_d  = c_rdata_q;
        d_rdata_d  = d_rdata_q;
        err_d      = err_q & ~bus.err_clr;
        owner_d    = owner_q;
        last_d     = last_q;
        pref_dma_d = pref_dma_q;
        burst_d    = burst_q;
        tmo_d      = tmo_q;
        lock       = owner_q && !last_q && (burst_q < BW'(MAXBURST)) && bus.d_req;
        grant_dma  = lock || (bus.d_req && (!bus.c_req || pref_dma_q));
        tmo_hit    = (tmo_q == TW'(TIMEOUT - 1));
        done       = bus.m_ack || tmo_hit;

        case (state_q)
            IDLE: begin
                tmo_d = '0;
                if (bus.c_req || bus.d_req) begin
                    m_req_d = 1'b1;
                    if (grant_dma) begin
                        state_d    = ACC_D;
                        m_we_d     = bus.d_we;
                        m_adr_d    = bus.d_adr;
                        m_wdata_d  = bus.d_wdata;
                        last_d     = bus.d_last;
                        owner_d    = 1'b1;
                        pref_dma_d = 1'b0;
                        if (bus.d_last)
                            burst_d = '0;
                        else if (burst_q != BW'(MAXBURST))
                            burst_d = burst_q + BW'(1);
                    end else begin
                        state_d    = ACC_C;
                        m_we_d     = bus.c_we;
                        m_adr_d    = bus.c_adr;
                        m_wdata_d  = bus.c_wdata;
                        owner_d    = 1'b0;
                        pref_dma_d = 1'b1;
                        burst_d    = '0;
                    end
                end
            end
            ACC_C, ACC_D: begin
                if (done) begin
                    // an ack wins over a timeout landing in the same cycle
                    if (state_q == ACC_C) begin
                        state_d   = RESP_C;
                        c_ack_d   = 1'b1;
                        c_rdata_d = bus.m_ack ? bus.m_rdata : '0;
                    end else begin
                        state_d   = RESP_D;
                        d_ack_d   = 1'b1;
                        d_rdata_d = bus.m_ack ? bus.m_rdata : '0;
                    end
                    if (!bus.m_ack)
                        err_d = 1'b1;
                end else begin
                    m_req_d = 1'b1;
                    tmo_d   = tmo_q + TW'(1);
                end
            end
            RESP_C, RESP_D: state_d = IDLE;
            default:        state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            m_req_q    <= 1'b0;
            m_we_q     <= 1'b0;
            m_adr_q    <= '0;
            m_wdata_q  <= '0;
            c_ack_q    <= 1'b0;
            d_ack_q    <= 1'b0;
            c_rdata_q  <= '0;
            d_rdata_q  <= '0;
            err_q      <= 1'b0;
            owner_q    <= 1'b0;
            last_q     <= 1'b1;
            pref_dma_q <= 1'b0;
            burst_q    <= '0;
            tmo_q      <= '0;
        end else begin
            state_q    <= state_d;
            m_req_q    <= m_req_d;
            m_we_q     <= m_we_d;
            m_adr_q    <= m_adr_d;
            m_wdata_q  <= m_wdata_d;
            c_ack_q    <= c_ack_d;
            d_ack_q    <= d_ack_d;
            c_rdata_q  <= c_rdata_d;
            d_rdata_q  <= d_rdata_d;
            err_q      <= err_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            pref_dma_q <= pref_dma_d;
            burst_q    <= burst_d;
            tmo_q      <= tmo_d;
        end
    end

    assign bus.m_req   = m_req_q;
    assign bus.m_we    = m_we_q;
    assign bus.m_adr   = m_adr_q;
    assign bus.m_wdata = m_wdata_q;
    assign bus.c_ack   = c_ack_q;
    assign bus.d_ack   = d_ack_q;
    assign bus.c_rdata = c_rdata_q;
    assign bus.d_rdata = d_rdata_q;
    assign bus.err     = err_q;
    assign bus.owner   = owner_q;
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the multicycle MIPS core's single unified memory port between the CPU and a DMA/loader requester. It sits between the `mips` memory interface (through a thin req/ack wrapper) and the memory. It serialises the two requesters with round-robin fairness and bounded DMA bursts. It also times out hung memory accesses and raises a sticky error flag.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width
- MAXBURST, 4, max consecutive DMA beats while CPU is pending (>=1)
- TIMEOUT, 255, ACC cycles without m_ack before forced completion (>=1)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- c_req / c_we  in  1 / 1  CPU request / write enable
- c_adr / c_wdata  in  AW / DW  CPU address / write data
- c_rdata / c_ack  out  DW / 1  CPU read data / one-cycle completion pulse
- d_req / d_we / d_last  in  1 / 1 / 1  DMA request / write / last beat of burst
- d_adr / d_wdata  in  AW / DW  DMA address / write data
- d_rdata / d_ack  out  DW / 1  DMA read data / completion pulse
- m_req / m_we  out  1 / 1  memory request / write
- m_adr / m_wdata  out  AW / DW  memory address / write data
- m_rdata / m_ack  in  DW / 1  memory read data / acknowledge
- err  out  1  sticky timeout flag
- err_clr  in  1  clears err
- owner  out  1  0 = CPU, 1 = DMA; current or last grant

## Operation
- Requester protocol: hold req and fields stable until ack. Fields may change in the cycle after ack. Dropping req before ack is a violation; the arbiter completes the access regardless.
- FSM states are IDLE, ACC_C, ACC_D, RESP_C and RESP_D.
- **IDLE:** m_req=0. If any req is high, pick a winner, latch its we/adr/wdata (and d_last) into the m_* registers, set owner, and go to ACC_x. Timeout counter clears.
- **Priority in IDLE:**
  - DMA burst lock: if the last grant was DMA, that beat's d_last=0, burst count < MAXBURST and d_req is high, DMA wins.
  - Otherwise round-robin: the requester not served last wins a tie.
  - A lone requester always wins.
  - After reset, the CPU wins the first tie.
- **ACC_x:** m_req=1, and m_we/m_adr/m_wdata are held stable.
  - On m_ack: capture m_rdata into x_rdata and go to RESP_x.
  - Otherwise increment the counter. On the TIMEOUT-th non-acked cycle, go to RESP_x, load x_rdata=0 and set err.
- **RESP_x:** x_ack=1 for exactly one cycle, m_req=0, next state IDLE.
- **Burst counter:**
  - Increments on each DMA grant.
  - Resets to 0 on a CPU grant, or when a DMA beat with d_last=1 is granted.
  - When the count reaches MAXBURST with CPU pending, the CPU wins next.
  - With CPU idle, DMA continues and the count saturates.
- **err / err_clr:** err stays set until err_clr. A timeout and err_clr in the same cycle leave err=1.
- x_rdata holds its value until the next read completion for that port. Writes also load x_rdata from m_rdata (don't-care content).

## Timing
- All outputs are registered. Reset values: m_req=0, m_we=0, m_adr=0, m_wdata=0, c_ack=0, d_ack=0, c_rdata=0, d_rdata=0, err=0, owner=0. State=IDLE, burst count=0, round-robin favours CPU.
- **Access sequence:**
  - req seen high in IDLE cycle T.
  - m_req high from T+1.
  - m_ack in cycle A >= T+1 (may be the first m_req cycle).
  - x_ack and x_rdata valid in A+1.
  - IDLE in A+2.
- Minimum access is 3 cycles. Back-to-back throughput is one access per 3 cycles with zero-wait memory.
- Reset asserted mid-access: all outputs return to reset values immediately (asynchronous). No ack is issued and the access is abandoned.
- m_ack outside ACC is ignored.

## Test plan
- **CPU read alone:** c_req, c_adr=0x100, memory acks in the first m_req cycle with 0x12345678 -> m_adr=0x100 from T+1; c_ack pulse at T+2 with c_rdata=0x12345678; d_ack never asserts.
- **CPU write:** c_we=1, c_adr=0x40, c_wdata=0xA5A5A5A5, memory acks after 3 wait cycles -> m_we, m_adr and m_wdata stable for all 4 m_req cycles; one c_ack.
- **Simultaneous requests:** both requesters high right after reset, single beats with d_last=1 -> CPU, DMA, CPU, DMA grant order (owner toggles).
- **DMA burst fairness:** MAXBURST=4, 6-beat DMA burst (d_last on beat 6), CPU requesting throughout -> grant order D D D D C D D.
- **Timeout:** TIMEOUT=8, memory never acks -> c_ack 8 cycles after m_req rises, c_rdata=0, err=1. err stays 1 through later good accesses until err_clr pulses; err_clr concurrent with a new timeout keeps err=1.
- **Reset in ACC_D:** reset asserted mid-access -> m_req=0 asynchronously, no d_ack. After release, a pending tie goes to the CPU.
